mux_scan_sequencer: RTL

Sequencer that sits directly upstream of the 4x1 multiplexer (MuxMod). It drives the mux select lines s1/s0 through inputs d0..d3 in order and samples the mux output after a programmable settle time. It assembles the four samples into a 4-bit word. A start/busy/done handshake lets a controller or testbench request one complete scan.

---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/mux_scan_timer.sv | 35 +++
 rtl/mux_scan_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the mux scan sequencer.
//   state_t : FSM state encoding (IDLE, SCAN, DONE), 2 bits
//   SEL_N   : number of mux inputs walked per scan
//   SEL_W   : width of the select code
//   CNT_W   : width of the settle counter
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SEL_N = 4;
    localparam int SEL_W = $clog2(SEL_N);
    localparam int CNT_W = 4;

endpackage

// File: rtl/mux_scan_timer.sv
// mux_scan_timer: loadable down counter that measures the settle time.
//   clk      in   system clock
//   rst      in   asynchronous active-high reset (count -> 0)
//   load     in   load load_val (has priority over dec)
//   load_val in   reload value
//   dec      in   decrement by one; holds at zero
//   zero     out  count == 0
module mux_scan_timer
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks the 4x1 mux select through d0..d3, samples the
// mux output after SETTLE cycles per code and assembles a 4-bit word.
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   start  in   scan request, honoured only in IDLE
//   o_in   in   mux output
//   s1,s0  out  mux select (registered), 00 outside a scan
//   busy   out  scan in progress
//   done   out  one-cycle pulse, q holds a complete scan
//   q      out  scan result, q[i] = o_in sampled while select = i
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       o_in,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       done,
    output logic [3:0] q
);

    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(SEL_N - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_N-1:0] q_q, q_d;
    logic [1:0]       s_q, s_d;
    logic             load, dec, zero;

    mux_scan_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (RELOAD),
        .dec      (dec),
        .zero     (zero)
    );

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        q_d     = q_q;
        load    = 1'b0;
        dec     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    sel_d   = '0;
                    q_d     = '0;
                    load    = 1'b1;
                end
            end
            SCAN: begin
                if (!zero) begin
                    dec = 1'b1;
                end else begin
                    q_d[sel_q] = o_in;
                    if (sel_q == SEL_MAX) begin
                        state_d = DONE;
                    end else begin
                        sel_d = sel_q + 1'b1;
                        load  = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Select lines are registered from the next-state view so they change
        // on the same edge as the FSM without a decode path after the flops.
        s_d = (state_d == SCAN) ? sel_d : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            q_q     <= '0;
            s_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            q_q     <= q_d;
            s_q     <= s_d;
        end
    end

    assign s1   = s_q[1];
    assign s0   = s_q[0];
    assign busy = (state_q == SCAN);
    assign done = (state_q == DONE);
    assign q    = q_q;

endmodule
